fetch_stage: RTL and testbench

//  Instruction-fetch stage of the LEGv8 CPU: owns the program counter, drives the

---
 rtl/fetch_stage.sv | 109 ++++++++++
 tb/tb_fetch_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, addresses the combinational ROM and
// fills the IF/ID register under decode back-pressure, redirects and fault halting.
module fetch_stage #(
    parameter logic [63:0] RESET_PC          = 64'd0,
    parameter logic [63:0] INSTRUCT_MEM_SIZE = 64'd1024,
    parameter int          CNT_W             = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [63:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    input  logic             redirect_valid,
    input  logic [63:0]      redirect_target,
    input  logic             id_ready,
    output logic             if_id_valid,
    output logic [63:0]      if_id_pc,
    output logic [31:0]      if_id_instr,
    output logic             fetch_fault,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state_q;
    logic [63:0]      pc_q;
    logic             valid_q;
    logic [63:0]      if_pc_q;
    logic [31:0]      if_instr_q;
    logic             fault_q;
    logic             halted_q;
    logic [CNT_W-1:0] cnt_q;

    logic [63:0]      pc_last_byte;
    logic [63:0]      pc_d;
    logic [CNT_W-1:0] cnt_d;
    logic             pc_ok;
    logic             slot_free;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The whole 4-byte word must lie inside the ROM; the 64-bit add also
    // rejects a PC that wrapped past 2^64 on the previous increment.
    assign pc_last_byte = pc_q + 64'd3;
    assign pc_ok        = (pc_q[1:0] == 2'b00) && (pc_last_byte < INSTRUCT_MEM_SIZE);
    assign slot_free    = !valid_q || id_ready;
    assign pc_d         = pc_q + 64'd4;
    assign cnt_d        = sat_inc(cnt_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            if_pc_q    <= 64'd0;
            if_instr_q <= 32'd0;
            fault_q    <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            fault_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (redirect_valid) begin
                        pc_q    <= redirect_target;
                        valid_q <= 1'b0;
                    end else if (!pc_ok) begin
                        state_q  <= HALT;
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                        if (id_ready) begin
                            valid_q <= 1'b0;
                        end
                    end else if (slot_free) begin
                        if_pc_q    <= pc_q;
                        if_instr_q <= imem_instr;
                        valid_q    <= 1'b1;
                        pc_q       <= pc_d;
                        cnt_q      <= cnt_d;
                    end
                end
                HALT: begin
                    // Terminal until reset; only the pending IF/ID entry may drain.
                    halted_q <= 1'b1;
                    if (id_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= HALT;
                end
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_valid = valid_q;
    assign if_id_pc    = if_pc_q;
    assign if_id_instr = if_instr_q;
    assign fetch_fault = fault_q;
    assign halted      = halted_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic, all compared
// against a transaction-level model of the fetch rules.
module tb_fetch_stage;

    localparam int          CW     = 4;
    localparam logic [63:0] MEMSZ  = 64'd1024;
    localparam logic [63:0] RST_PC = 64'd0;
    localparam int          CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [63:0]   imem_addr;
    logic [31:0]   imem_instr;
    logic          redirect_valid;
    logic [63:0]   redirect_target;
    logic          id_ready;
    logic          if_id_valid;
    logic [63:0]   if_id_pc;
    logic [31:0]   if_id_instr;
    logic          fetch_fault;
    logic          halted;
    logic [CW-1:0] fetch_count;

    logic [31:0] rom [256];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [63:0] m_pc;
    bit          m_halt;
    bit          m_valid;
    logic [63:0] m_ifpc;
    logic [31:0] m_ifinstr;
    int          m_cnt;
    bit          m_fault;

    fetch_stage #(
        .RESET_PC          (RST_PC),
        .INSTRUCT_MEM_SIZE (MEMSZ),
        .CNT_W             (CW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .id_ready        (id_ready),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr),
        .fetch_fault     (fetch_fault),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_instr = rom[imem_addr[9:2]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = RST_PC;
        m_halt    = 0;
        m_valid   = 0;
        m_ifpc    = 64'd0;
        m_ifinstr = 32'd0;
        m_cnt     = 0;
        m_fault   = 0;
    endtask

    // One clock edge of the fetch rules, evaluated on the values present before it.
    task automatic model_edge(input bit rdv, input logic [63:0] tgt, input bit rdy);
        bit ok;
        m_fault = 0;
        if (m_halt) begin
            if (rdy) m_valid = 0;
            return;
        end
        ok = (m_pc % 4 == 0) && ((m_pc + 64'd3) < MEMSZ);
        if (rdv) begin
            m_pc    = tgt;
            m_valid = 0;
        end else if (!ok) begin
            m_halt  = 1;
            m_fault = 1;
            if (rdy) m_valid = 0;
        end else if (!m_valid || rdy) begin
            m_ifpc    = m_pc;
            m_ifinstr = rom[m_pc[9:2]];
            m_valid   = 1;
            m_pc      = m_pc + 64'd4;
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".addr"},  imem_addr,   m_pc);
        chk({tag, ".valid"}, 64'(if_id_valid), 64'(m_valid));
        chk({tag, ".ifpc"},  if_id_pc,    m_ifpc);
        chk({tag, ".instr"}, 64'(if_id_instr), 64'(m_ifinstr));
        chk({tag, ".fault"}, 64'(fetch_fault), 64'(m_fault));
        chk({tag, ".halted"}, 64'(halted), 64'(m_halt));
        chk({tag, ".count"}, 64'(fetch_count), 64'(m_cnt));
    endtask

    task automatic step(input bit rdv, input logic [63:0] tgt, input bit rdy, input string tag);
        redirect_valid  = rdv;
        redirect_target = tgt;
        id_ready        = rdy;
        model_edge(rdv, tgt, rdy);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    // Asserted and released between edges, checked before any clock arrives.
    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all(tag);
        #2;
        reset_n = 1'b1;
    endtask

    logic [63:0] tgt_r;
    int          sel;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[0] = 32'h91000421;
        rom[1] = 32'h91000842;
        redirect_valid  = 1'b0;
        redirect_target = 64'd0;
        id_ready        = 1'b1;
        reset_n         = 1'b0;
        model_reset();
        #3;
        compare_all("reset");
        chk("reset.addr_const", imem_addr, RST_PC);
        reset_n = 1'b1;

        // Straight-line fetch
        step(0, 0, 1, "t1e1");
        chk("t1e1.pc0",    if_id_pc, 64'd0);
        chk("t1e1.instr0", 64'(if_id_instr), 64'h91000421);
        chk("t1e1.addr4",  imem_addr, 64'd4);
        step(0, 0, 1, "t1e2");
        chk("t1e2.pc4",    if_id_pc, 64'd4);
        chk("t1e2.instr1", 64'(if_id_instr), 64'h91000842);
        step(0, 0, 1, "t1e3");
        step(0, 0, 1, "t1e4");
        chk("t1e4.cnt4", 64'(fetch_count), 64'd4);

        // Decode back-pressure
        async_reset("t2rst");
        for (int i = 0; i < 3; i++) step(0, 0, 1, "t2fill");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, "t2stall");
            chk("t2stall.pc8", if_id_pc, 64'h8);
            chk("t2stall.addrC", imem_addr, 64'hC);
            chk("t2stall.cnt3", 64'(fetch_count), 64'd3);
        end
        step(0, 0, 1, "t2resume");
        chk("t2resume.pcC", if_id_pc, 64'hC);

        // Redirect during a stall drops the held entry
        step(1, 64'h40, 0, "t3redir");
        chk("t3redir.valid0", 64'(if_id_valid), 64'd0);
        chk("t3redir.addr40", imem_addr, 64'h40);
        step(0, 0, 1, "t3cap");
        chk("t3cap.pc40", if_id_pc, 64'h40);

        // Run off the end of the ROM
        step(1, 64'h3F0, 1, "t4redir");
        for (int i = 0; i < 4; i++) step(0, 0, 1, "t4run");
        chk("t4run.pc3FC", if_id_pc, 64'h3FC);
        step(0, 0, 0, "t4halt");
        chk("t4halt.fault", 64'(fetch_fault), 64'd1);
        chk("t4halt.halted", 64'(halted), 64'd1);
        chk("t4halt.addr400", imem_addr, 64'h400);
        step(0, 0, 1, "t4drain");
        chk("t4drain.fault0", 64'(fetch_fault), 64'd0);
        chk("t4drain.valid0", 64'(if_id_valid), 64'd0);
        step(1, 64'h0, 1, "t4ignore");
        chk("t4ignore.addr400", imem_addr, 64'h400);

        // Misaligned redirect target
        async_reset("t5rst");
        step(1, 64'h42, 1, "t5bubble");
        step(0, 0, 1, "t5halt");
        chk("t5halt.fault", 64'(fetch_fault), 64'd1);
        chk("t5halt.valid0", 64'(if_id_valid), 64'd0);
        step(0, 0, 1, "t5after");

        // Asynchronous reset in the middle of a stall
        async_reset("t6pre");
        step(0, 0, 1, "t6a");
        step(0, 0, 1, "t6b");
        step(0, 0, 0, "t6stall");
        async_reset("t6rst");
        chk("t6rst.cnt0", 64'(fetch_count), 64'd0);
        step(0, 0, 1, "t6resume");
        chk("t6resume.pc0", if_id_pc, RST_PC);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rnd_rst");
            end
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3, 4, 5, 6: tgt_r = 64'($urandom_range(0, 255)) * 64'd4;
                7:                   tgt_r = 64'h3F0 + 64'($urandom_range(0, 3)) * 64'd4;
                8:                   tgt_r = 64'($urandom_range(0, 1023));
                default:             tgt_r = ($urandom_range(0, 1) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                                                         : {32'($urandom), 32'($urandom)};
            endcase
            step(($urandom_range(0, 11) == 0), tgt_r, ($urandom_range(0, 3) != 0), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
